// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with combinational reads, synchronous
// writes, write-to-read bypass (highest write port wins) and a sequential
// clear engine that zeroes every entry after reset or on request.
// Optional feature macro: REGFILE_ZERO_REG_EN (entry 0 hardwired to zero).
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     clr_req_i,
    output logic                     ready_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [NUM_WR-1:0]   w_wr_ok;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;

    // State register and clear counter; reset restarts the clear from entry 0
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next-state logic: walk the counter through every entry, then go READY
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_nxt   = S_READY;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            S_READY: begin
                if (clr_req_i) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // Effective write enables: only in READY, and never to the hardwired zero entry
    always_comb begin
        w_wr_ok = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_ok[j] = wr_en_i[j] && (r_state == S_READY) &&
                         !(ZERO_REG && (wr_addr_i[j*ADDR_W +: ADDR_W] == '0));
        end
    end

    // Storage update: clear engine in CLEAR, otherwise ports in ascending order so the highest index wins
    always_ff @(posedge clk_i) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j]) begin
                    r_mem[wr_addr_i[j*ADDR_W +: ADDR_W]] <= wr_data_i[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read path: stored value overridden by same-cycle writes, forced to zero in CLEAR
    always_comb begin
        w_rd_data = '0;
        if (r_state == S_READY) begin
            for (int k = 0; k < NUM_RD; k++) begin
                w_rd_data[k*DATA_W +: DATA_W] = r_mem[rd_addr_i[k*ADDR_W +: ADDR_W]];
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wr_ok[j] &&
                        (wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i[k*ADDR_W +: ADDR_W])) begin
                        w_rd_data[k*DATA_W +: DATA_W] = wr_data_i[j*DATA_W +: DATA_W];
                    end
                end
                if (ZERO_REG && (rd_addr_i[k*ADDR_W +: ADDR_W] == '0)) begin
                    w_rd_data[k*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    assign rd_data_o = w_rd_data;
    assign ready_o   = (r_state == S_READY);

endmodule
